rgb_mem_streamer: RTL and testbench

- Readback end of the demosaic datapath. After the demosaic core has filled the three 128x128 R/G/B planes (8-bit per channel, 14-bit address {row[6:0], col[6:0]}), this block reads them out in raster order.
- Emits one full-RGB pixel per handshake on a valid/ready stream.
- Also emits the re-mosaiced Bayer sample for that pixel, used for loopback checks against the original input stream.

---
 rtl/rgb_mem_streamer_pkg.sv | 38 +++
 rtl/rgb_mem_streamer_fifo.sv | 51 +++++
 rtl/rgb_mem_streamer.sv | 134 +++++++++++++
 tb/tb_rgb_mem_streamer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_mem_streamer_pkg.sv
// rtl/rgb_mem_streamer_pkg.sv - shared constants, types and Bayer select for the RGB plane readback path
package rgb_mem_streamer_pkg;

  localparam int ADDR_W     = 14;
  localparam int COL_W      = 7;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 2;
  localparam logic [ADDR_W-1:0] IMG_LAST = 14'd16383;

  typedef enum logic [1:0] {CH_R, CH_G, CH_B} channel_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } pixel_t;

  localparam int PIX_W = $bits(pixel_t);

  // Row parity sits in the LSB of the row field, column parity in bit 0.
  function automatic channel_e bayer_channel(input logic [ADDR_W-1:0] addr);
    logic row_odd;
    logic col_odd;
    row_odd = addr[COL_W];
    col_odd = addr[0];
    if (row_odd == col_odd) begin
      return CH_G;
    end else if (row_odd) begin
      return CH_B;
    end else begin
      return CH_R;
    end
  endfunction

endpackage

// File: rtl/rgb_mem_streamer_fifo.sv
// rtl/rgb_mem_streamer_fifo.sv - two-entry output skid FIFO carrying {addr, r, g, b}
module stream_skid_fifo
  import rgb_mem_streamer_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [PIX_W-1:0] din_i,
  input  logic             pop_i,
  output logic [PIX_W-1:0] dout_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PIX_W-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'(FIFO_DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign count_d = count_q + {1'b0, push_i} - {1'b0, do_pop};

  // The caller guarantees push_i never lands on a full FIFO without a pop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rgb_mem_streamer.sv
// rtl/rgb_mem_streamer.sv - raster readback of the R/G/B planes into a pixel stream with re-mosaiced Bayer sample
module rgb_mem_streamer
  import rgb_mem_streamer_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_r_o,
  input  logic [DATA_W-1:0] rdata_r_i,
  output logic [ADDR_W-1:0] addr_g_o,
  input  logic [DATA_W-1:0] rdata_g_i,
  output logic [ADDR_W-1:0] addr_b_o,
  input  logic [DATA_W-1:0] rdata_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_r_o,
  output logic [DATA_W-1:0] out_g_o,
  output logic [DATA_W-1:0] out_b_o,
  output logic [DATA_W-1:0] out_bayer_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q;
  logic              armed_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_addr_q;
  logic              done_q;

  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_dout;
  pixel_t            push_data;
  pixel_t            head;
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;

  assign pop       = out_valid_o & out_ready_i;
  assign push      = inflight_q & (~fifo_full | pop);
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  // A read issued now lands two edges later; counting the one already in
  // flight keeps a slot for it even if the sink stalls from here on.
  assign issue     = (state_q == ST_RUN) && armed_q && (occupancy < 3'(FIFO_DEPTH));

  assign push_data = '{addr: inflight_addr_q, r: rdata_r_i, g: rdata_g_i, b: rdata_b_i};

  stream_skid_fifo u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head = pixel_t'(fifo_dout);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      armed_q         <= 1'b0;
      ptr_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_addr_q <= ptr_q;
      // First read goes out one edge after RUN is entered.
      armed_q         <= (state_q == ST_RUN);
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            ptr_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (ptr_q == IMG_LAST) begin
              state_q <= ST_DRAIN;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last_o) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_en_o     = issue;
  assign addr_r_o    = ptr_q;
  assign addr_g_o    = ptr_q;
  assign addr_b_o    = ptr_q;

  assign out_valid_o = ~fifo_empty;
  assign out_r_o     = head.r;
  assign out_g_o     = head.g;
  assign out_b_o     = head.b;
  assign out_addr_o  = head.addr;
  assign out_last_o  = out_valid_o && (head.addr == IMG_LAST);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

  always_comb begin
    out_bayer_o = head.g;
    case (bayer_channel(head.addr))
      CH_R:    out_bayer_o = head.r;
      CH_B:    out_bayer_o = head.b;
      default: out_bayer_o = head.g;
    endcase
  end

endmodule

// File: tb/tb_rgb_mem_streamer.sv
// tb/tb_rgb_mem_streamer.sv - scoreboard bench for rgb_mem_streamer
module tb_rgb_mem_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rd_en;
  logic [13:0] addr_r, addr_g, addr_b;
  logic [7:0]  rdata_r = 8'h00, rdata_g = 8'h00, rdata_b = 8'h00;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r, out_g, out_b, out_bayer;
  logic [13:0] out_addr;
  logic        out_last, busy, done;

  always #5 clk = ~clk;

  rgb_mem_streamer dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .rd_en_o(rd_en),
    .addr_r_o(addr_r), .rdata_r_i(rdata_r), .addr_g_o(addr_g), .rdata_g_i(rdata_g),
    .addr_b_o(addr_b), .rdata_b_i(rdata_b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_r_o(out_r), .out_g_o(out_g), .out_b_o(out_b), .out_bayer_o(out_bayer),
    .out_addr_o(out_addr), .out_last_o(out_last), .busy_o(busy), .done_o(done)
  );

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  r, g, b, bay;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   outstanding = 0, rd_total = 0, hs_frame = 0, done_cnt = 0;
  int   last_hs_cyc = 0, first_valid_cyc = -1, done_cyc = 0, frame_id = 0, e0 = 0;
  bit   contig_on = 0, rand_mode = 0, stall_q = 0, prev_done = 0;
  exp_t snap;

  always @(posedge clk) cyc++;

  // Synchronous-read planes: R=addr[7:0], G=addr[13:6], B=~addr[7:0]
  always @(posedge clk) begin
    if (rd_en) begin
      rdata_r <= addr_r[7:0];
      rdata_g <= addr_g[13:6];
      rdata_b <= ~addr_b[7:0];
    end
  end

  function automatic exp_t model(input int a);
    exp_t e;
    logic [13:0] ad;
    ad = a[13:0];
    e.addr = ad;
    e.r = ad[7:0];
    e.g = ad[13:6];
    e.b = ~ad[7:0];
    if (ad[7] == ad[0])      e.bay = e.g;
    else if (ad[7])          e.bay = e.b;
    else                     e.bay = e.r;
    e.last = (ad == 14'd16383);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t cur_out();
    exp_t c;
    c = '{addr: out_addr, r: out_r, g: out_g, b: out_b, bay: out_bayer, last: out_last};
    return c;
  endfunction

  // Monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    bit hs;
    exp_t c, e;
    if (reset) begin
      outstanding = 0;
      stall_q = 0;
      prev_done = 0;
    end else begin
      hs = out_valid && out_ready;
      c = cur_out();
      if (rd_en) begin
        rd_total++;
        chk("addr_same", {addr_g, addr_b}, {addr_r, addr_r});
      end
      outstanding = outstanding + (rd_en ? 1 : 0) - (hs ? 1 : 0);
      if (rd_en) chk("rd_budget", outstanding <= 2, 1);
      if (stall_q && out_valid) chk("hold", c, snap);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hs) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel actual=%0h expected=none", c);
        end else begin
          e = sb.pop_front();
          chk("pixel", c, e);
          if (frame_id == 1) begin
            if (out_addr == 14'd0)   chk("bayer_0",   out_bayer, 8'h00);
            if (out_addr == 14'd1)   chk("bayer_1",   out_bayer, 8'h01);
            if (out_addr == 14'd128) chk("bayer_128", out_bayer, 8'h7F);
            if (out_addr == 14'd129) chk("bayer_129", out_bayer, 8'h02);
          end
          if (contig_on && out_addr != 14'd0) chk("one_per_cycle", cyc, last_hs_cyc + 1);
        end
        hs_frame++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_last", cyc, last_hs_cyc + 1);
        chk("busy_with_done", busy, 1);
      end
      if (prev_done) chk("done_busy_fall", {done, busy}, 0);
      prev_done = done;
      stall_q = out_valid && !out_ready;
      snap = c;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 99) >= 30);
    end
  end

  task automatic check_reset_outputs(input string name);
    chk({name, "_rd"}, {rd_en, addr_r, addr_g, addr_b}, 0);
    chk({name, "_out"}, {out_valid, out_r, out_g, out_b, out_bayer, out_addr, out_last, busy, done}, 0);
  endtask

  task automatic begin_frame();
    done_cnt = 0;
    hs_frame = 0;
    first_valid_cyc = -1;
    for (int a = 0; a < 16384; a++) sb.push_back(model(a));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    bit got;
    got = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  initial begin
    bit got;
    int base;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1 reset = 1'b0;

    // Frame 1: ready held high
    frame_id = 1; out_ready = 1'b1; contig_on = 1;
    begin_frame();
    wait_done("t1", 20000);
    chk("t1_latency", first_valid_cyc - e0, 3);
    chk("t1_frame_cycles", done_cyc - e0, 16387);
    chk("t1_hs", hs_frame, 16384);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_drained", sb.size(), 0);
    contig_on = 0;
    repeat (5) @(posedge clk);

    // Frame 2: stall 50 cycles, then start re-pulsed mid-frame and on done
    frame_id = 2; #1 out_ready = 1'b0;
    begin_frame();
    base = rd_total;
    repeat (50) @(posedge clk);
    chk("stall_reads", rd_total - base, 2);
    chk("stall_no_hs", hs_frame, 0);
    #1 out_ready = 1'b1;
    repeat (3000) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL t2_last_timeout actual=no_last expected=last");
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(negedge clk);
    chk("t2_hs", hs_frame, 16384);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_drained", sb.size(), 0);
    chk("t2_idle_after", {busy, out_valid}, 0);

    // Frame 3: aborted by reset after 5000 pixels
    frame_id = 3;
    begin_frame();
    got = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (hs_frame >= 5000) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL t3_hs_timeout actual=%0d expected=5000", hs_frame);
    end
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_midframe");
    chk("abort_no_done", done_cnt, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    // Frame 4: restart after abort with random backpressure
    frame_id = 4; rand_mode = 1;
    begin_frame();
    wait_done("t4", 60000);
    rand_mode = 0;
    chk("t4_latency", first_valid_cyc - e0, 3);
    chk("t4_hs", hs_frame, 16384);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
